// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit framer: FSM states and the line-mux select codes.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_line_mux.sv
// Registered 4:1 serial line driver; one cycle behind its select, resets to the idle-high level.
module uart_tx_line_mux
    import uart_tx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] sel,
    input  logic       data_bit,
    input  logic       par_bit,
    output logic       line
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            line <= 1'b1;
        end else begin
            case (sel)
                SEL_START: line <= 1'b0;
                SEL_DATA:  line <= data_bit;
                SEL_PAR:   line <= par_bit;
                default:   line <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_W bits LSB first, optional parity, 1 or 2 stops, one bit per CLK.
// TX_OUT lags the FSM by one cycle; a new word is accepted only in IDLE or on the last stop cycle.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic              TX_OUT,
    output logic              BUSY
);

    localparam int CNT_W = $clog2(DATA_W);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
            $error("uart_tx_frame: DATA_W must be in 5..9");
        end
    endgenerate

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic [DATA_W-1:0] shd_data;
    logic              shd_par_en;
    logic              shd_par_typ;
    logic              shd_stop2;
    logic              load;
    logic              last_bit;
    logic              last_stop;
    logic              par_bit;
    logic [1:0]        sel;

    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign last_stop = (stop_cnt == shd_stop2);
    assign par_bit   = (^shd_data) ^ shd_par_typ;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel       = SEL_STOP;
        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                sel       = SEL_START;
                state_nxt = DATA;
            end
            DATA: begin
                sel = SEL_DATA;
                if (last_bit) begin
                    state_nxt = shd_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                sel       = SEL_PAR;
                state_nxt = STOP;
            end
            STOP: begin
                // Accepting on the final stop edge gives gap-free back-to-back frames.
                if (last_stop) begin
                    if (DATA_VALID) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            BUSY  <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            bit_cnt  <= (state == DATA && !last_bit) ? bit_cnt + CNT_W'(1) : '0;
            stop_cnt <= (state == STOP && !last_stop) ? 1'b1 : 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shd_data    <= '0;
            shd_par_en  <= 1'b0;
            shd_par_typ <= 1'b0;
            shd_stop2   <= 1'b0;
        end else if (load) begin
            shd_data    <= P_DATA;
            shd_par_en  <= PAR_EN;
            shd_par_typ <= PAR_TYP;
            shd_stop2   <= STOP2;
        end
    end

    uart_tx_line_mux u_line_mux (
        .CLK      (CLK),
        .RST      (RST),
        .sel      (sel),
        .data_bit (shd_data[bit_cnt]),
        .par_bit  (par_bit),
        .line     (TX_OUT)
    );

endmodule
